mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; all state updates on this edge.
REQ-002 SHALL have ports: resetn  in  1  reset, asynchronous and active-low.
REQ-003 SHALL have ports: stall  in  6  pipeline stall vector; bit3 = MEM held, bit4 = WB held; 1 = stop.
REQ-004 SHALL have ports: ex_to_mem_bus  in  146  packed, MSB first, fields listed below.
- data_ram_readen[4]
- hi_we, lo_we
- hi_ex[32], lo_ex[32]
- ex_pc[32]
- data_ram_en
- data_ram_wen[4]
- sel_rf_res
- rf_we
- rf_waddr[5]
- ex_result[32]
REQ-005 SHALL have ports: data_sram_rdata  in  32  synchronous SRAM read data; valid in the first cycle an instruction occupies MEM.
REQ-006 SHALL have ports: mem_to_wb_bus  out  136  packed, MSB first, fields listed below.
- hi_we, lo_we
- hi[32], lo[32]
- pc[32]
- rf_we
- rf_waddr[5]
- rf_wdata[32]
REQ-007 SHALL have ports: mem_to_id_bus  out  104  forwarding bus: {hi_we, lo_we, hi, lo, rf_we, rf_waddr, rf_wdata}, same values as mem_to_wb_bus.

Function
REQ-008 SHALL register ex_to_mem_bus into mem_r each clk edge when stall[3]=0.
REQ-009 SHALL load mem_r with all-zero (bubble) when stall[3]=1 and stall[4]=0.
REQ-010 SHALL hold mem_r unchanged when stall[3]=1 and stall[4]=1.
REQ-011 SHALL implement the read-data capture FSM, states listed below.
- States: FRESH (use live data_sram_rdata), HELD (use rdata_hold register).
- FRESH -> HELD: stall[3]=1 and stall[4]=1; rdata_hold <= data_sram_rdata on the same edge.
- HELD -> HELD: while the hold condition persists; rdata_hold does not change.
- HELD -> FRESH: mem_r reloads or bubbles.
- Effective read data: rdata_eff = HELD ? rdata_hold : data_sram_rdata.
REQ-012 SHALL decode load type from data_ram_readen when data_ram_en=1 and data_ram_wen=0, using the encodings below; any other code is treated as lw.
- 1111 = lw
- 0001 = lb
- 0010 = lbu
- 0011 = lh
- 0100 = lhu
REQ-013 SHALL select bytes using addr = ex_result[1:0], as follows.
- Byte loads: select rdata_eff[8*addr+7 : 8*addr].
- Halfword loads: select [31:16] if addr[1]=1, else [15:0]; addr[0] is ignored.
REQ-014 SHALL sign-extend results for lb/lh and zero-extend for lbu/lhu; lw passes the word unchanged.
REQ-015 SHALL drive rf_wdata = extended load data when sel_rf_res=1, else ex_result.
REQ-016 SHALL pass hi_we, lo_we, hi, lo, pc, rf_we and rf_waddr through from mem_r unchanged.
REQ-017 SHALL force hi_we, lo_we and rf_we to 0 while mem_r is a bubble (all zero).
REQ-018 SHALL keep both output buses combinational from mem_r and rdata_eff, so data appears in the same cycle the instruction occupies MEM.
REQ-019 SHALL leave store instructions (data_ram_wen != 0) with rf_we as received; no data is extracted for stores.

Reset
REQ-020 SHALL clear mem_r to all-zero and put the FSM in FRESH immediately on resetn=0, independent of clk.
REQ-021 SHALL hold all output bus fields at 0 during reset.
REQ-022 SHALL discard an in-flight load held in MEM when reset is asserted mid-stall; after release the first instruction starts in FRESH.

Verification
REQ-023 SHALL pass: lb at ex_result=0x...03, rdata=0x80123456 -> rf_wdata=0xFFFFFF80.
REQ-024 SHALL pass: lhu at ex_result=0x...02, rdata=0x9ABC1234 -> rf_wdata=0x00009ABC; lh at the same address -> 0xFFFF9ABC.
REQ-025 SHALL pass: lw in MEM, rdata=0x11223344, stall[4:3]=11 for 3 cycles while rdata changes to 0xDEADBEEF -> rf_wdata stays 0x11223344 throughout the stall.
REQ-026 SHALL pass: stall[4:3]=01 -> next cycle mem_to_wb_bus=0; rf_we=0, hi_we=0, lo_we=0.
REQ-027 SHALL pass: mult result hi=0x1, lo=0x2 with hi_we=lo_we=1 -> both buses show hi=0x1, lo=0x2, and those values are visible on mem_to_id_bus the same cycle.
REQ-028 SHALL pass: resetn pulsed low between clk edges during a HELD lw -> outputs are 0 immediately; after release the next lw uses live rdata.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bus bundle between the EX/MEM pipeline boundary and the MEM stage.
// The pipeline side (master) drives stall, the EX payload and SRAM read
// data; the MEM stage (slave) returns the WB and ID forwarding buses.
interface mem_stage_if;
    logic [5:0]   stall;
    logic [145:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [135:0] mem_to_wb_bus;
    logic [103:0] mem_to_id_bus;

    modport master (
        output stall,
        output ex_to_mem_bus,
        output data_sram_rdata,
        input  mem_to_wb_bus,
        input  mem_to_id_bus
    );

    modport slave (
        input  stall,
        input  ex_to_mem_bus,
        input  data_sram_rdata,
        output mem_to_wb_bus,
        output mem_to_id_bus
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX payload, extracts and extends load
// data from the synchronous data SRAM, and presents the WB and ID
// forwarding buses combinationally from the registered instruction.
module mem_stage (
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave bus
);

    typedef enum logic {
        FRESH,
        HELD
    } rd_state_t;

    typedef enum logic [2:0] {
        LD_W,
        LD_B,
        LD_BU,
        LD_H,
        LD_HU
    } ld_kind_t;

    logic [145:0] mem_r;
    rd_state_t    state_q;
    rd_state_t    state_d;
    logic [31:0]  rdata_hold;
    logic [31:0]  rdata_hold_d;
    logic [31:0]  rdata_eff;
    logic         mem_hold;
    logic         mem_bubble;

    // Payload fields of the instruction currently in MEM
    logic [3:0]   mem_readen;
    logic         mem_hi_we;
    logic         mem_lo_we;
    logic [31:0]  mem_hi;
    logic [31:0]  mem_lo;
    logic [31:0]  mem_pc;
    logic         mem_ram_en;
    logic [3:0]   mem_ram_wen;
    logic         mem_sel_rf_res;
    logic         mem_rf_we;
    logic [4:0]   mem_rf_waddr;
    logic [31:0]  mem_result;
    logic [1:0]   mem_addr;

    logic         is_load;
    ld_kind_t     ld_kind;
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;
    logic [31:0]  load_ext;

    logic         out_hi_we;
    logic         out_lo_we;
    logic         out_rf_we;
    logic [31:0]  out_rf_wdata;

    // Stall bits 0-2 and 5 belong to other stages
    logic         unused_stall;
    assign unused_stall = ^{bus.stall[5], bus.stall[2:0]};

    // MEM and WB both held: MEM keeps its instruction and the SRAM word
    assign mem_hold = bus.stall[3] & bus.stall[4];

    // Pipeline register: load, bubble, or hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_r <= '0;
        end else if (!bus.stall[3]) begin
            mem_r <= bus.ex_to_mem_bus;
        end else if (!bus.stall[4]) begin
            mem_r <= '0;
        end
    end

    // Read-data capture state and held word
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= FRESH;
            rdata_hold <= '0;
        end else begin
            state_q    <= state_d;
            rdata_hold <= rdata_hold_d;
        end
    end

    // Capture the SRAM word on the edge that starts a hold; keep it until
    // MEM reloads or bubbles, since the SRAM output is only valid for one cycle
    always_comb begin
        state_d      = FRESH;
        rdata_hold_d = rdata_hold;
        case (state_q)
            FRESH: begin
                if (mem_hold) begin
                    state_d      = HELD;
                    rdata_hold_d = bus.data_sram_rdata;
                end
            end
            HELD: begin
                if (mem_hold) begin
                    state_d = HELD;
                end
            end
            default: begin
                state_d = FRESH;
            end
        endcase
    end

    assign rdata_eff = (state_q == HELD) ? rdata_hold : bus.data_sram_rdata;

    assign mem_readen     = mem_r[145:142];
    assign mem_hi_we      = mem_r[141];
    assign mem_lo_we      = mem_r[140];
    assign mem_hi         = mem_r[139:108];
    assign mem_lo         = mem_r[107:76];
    assign mem_pc         = mem_r[75:44];
    assign mem_ram_en     = mem_r[43];
    assign mem_ram_wen    = mem_r[42:39];
    assign mem_sel_rf_res = mem_r[38];
    assign mem_rf_we      = mem_r[37];
    assign mem_rf_waddr   = mem_r[36:32];
    assign mem_result     = mem_r[31:0];
    assign mem_addr       = mem_result[1:0];

    assign is_load    = mem_ram_en & (mem_ram_wen == 4'b0000);
    assign mem_bubble = (mem_r == '0);

    // Load type decode; unknown codes fall back to a full word
    always_comb begin
        ld_kind = LD_W;
        if (is_load) begin
            case (mem_readen)
                4'b0001: ld_kind = LD_B;
                4'b0010: ld_kind = LD_BU;
                4'b0011: ld_kind = LD_H;
                4'b0100: ld_kind = LD_HU;
                default: ld_kind = LD_W;
            endcase
        end
    end

    // Byte/halfword lane select and sign/zero extension
    always_comb begin
        byte_sel = rdata_eff[7:0];
        case (mem_addr)
            2'd0: byte_sel = rdata_eff[7:0];
            2'd1: byte_sel = rdata_eff[15:8];
            2'd2: byte_sel = rdata_eff[23:16];
            2'd3: byte_sel = rdata_eff[31:24];
            default: byte_sel = rdata_eff[7:0];
        endcase
        half_sel = mem_addr[1] ? rdata_eff[31:16] : rdata_eff[15:0];
        case (ld_kind)
            LD_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   load_ext = {24'h000000, byte_sel};
            LD_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_ext = {16'h0000, half_sel};
            default: load_ext = rdata_eff;
        endcase
    end

    // Write-back data and enables; bubbles never write
    always_comb begin
        out_rf_wdata = (mem_sel_rf_res && is_load) ? load_ext : mem_result;
        out_hi_we    = mem_hi_we & ~mem_bubble;
        out_lo_we    = mem_lo_we & ~mem_bubble;
        out_rf_we    = mem_rf_we & ~mem_bubble;
    end

    assign bus.mem_to_wb_bus = {out_hi_we, out_lo_we, mem_hi, mem_lo, mem_pc,
                                out_rf_we, mem_rf_waddr, out_rf_wdata};
    assign bus.mem_to_id_bus = {out_hi_we, out_lo_we, mem_hi, mem_lo,
                                out_rf_we, mem_rf_waddr, out_rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/hold/bubble/reset cases
// plus randomized traffic compared against an instruction-level model.
module tb_mem_stage;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    mem_stage_if ifc ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: the instruction in MEM and the SRAM word frozen by a hold
    logic [145:0] m_instr;
    logic         m_held;
    logic [31:0]  m_hold_val;

    // Model advances per instruction-level rules of the stage
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_instr    <= '0;
            m_held     <= 1'b0;
            m_hold_val <= '0;
        end else if (ifc.stall[3] && ifc.stall[4]) begin
            if (!m_held) begin
                m_held     <= 1'b1;
                m_hold_val <= ifc.data_sram_rdata;
            end
        end else begin
            m_held  <= 1'b0;
            m_instr <= ifc.stall[3] ? '0 : ifc.ex_to_mem_bus;
        end
    end

    function automatic logic [145:0] mk(input logic [3:0] readen, input logic hi_we,
                                        input logic lo_we, input logic [31:0] hi,
                                        input logic [31:0] lo, input logic [31:0] pc,
                                        input logic en, input logic [3:0] wen,
                                        input logic sel, input logic we,
                                        input logic [4:0] waddr, input logic [31:0] res);
        return {readen, hi_we, lo_we, hi, lo, pc, en, wen, sel, we, waddr, res};
    endfunction

    // Expected WB bus from the instruction fields and the read word it sees
    function automatic logic [135:0] exp_wb(input logic [145:0] ins, input logic [31:0] rd);
        logic [3:0]  readen;
        logic [31:0] res;
        logic [31:0] ld;
        logic [31:0] part;
        int unsigned a;
        logic        load;
        readen = ins[145:142];
        res    = ins[31:0];
        a      = res[1:0];
        load   = ins[43] && (ins[42:39] == 4'b0000);
        case (readen)
            4'b0001: begin
                part = (rd >> (8 * a)) & 32'hFF;
                ld   = part[7] ? (part | 32'hFFFFFF00) : part;
            end
            4'b0010: ld = (rd >> (8 * a)) & 32'hFF;
            4'b0011: begin
                part = (a >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
                ld   = part[15] ? (part | 32'hFFFF0000) : part;
            end
            4'b0100: ld = (a >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
            default: ld = rd;
        endcase
        return {ins[141:140], ins[139:76], ins[75:44], ins[37], ins[36:32],
                (ins[38] && load) ? ld : res};
    endfunction

    function automatic logic [135:0] model_wb();
        return exp_wb(m_instr, m_held ? m_hold_val : ifc.data_sram_rdata);
    endfunction

    function automatic logic [103:0] id_of(input logic [135:0] wb);
        return {wb[135:134], wb[133:70], wb[37:0]};
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn                = 1'b0;
        ifc.stall             = 6'd0;
        ifc.ex_to_mem_bus     = {$urandom, $urandom, $urandom, $urandom, $urandom};
        ifc.data_sram_rdata   = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ifc.mem_to_wb_bus !== 136'd0) begin
            failures++;
            $display("FAIL reset_wb got=%h exp=0", ifc.mem_to_wb_bus);
        end
        checks++;
        if (ifc.mem_to_id_bus !== 104'd0) begin
            failures++;
            $display("FAIL reset_id got=%h exp=0", ifc.mem_to_id_bus);
        end
        ifc.ex_to_mem_bus = '0;
        #2 resetn = 1'b1;
    endtask

    task automatic run_load(input string name, input logic [3:0] readen,
                            input logic [31:0] addr, input logic [31:0] rd,
                            input logic [31:0] exp);
        ifc.stall         = 6'd0;
        ifc.ex_to_mem_bus = mk(readen, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0040_0100,
                               1'b1, 4'b0000, 1'b1, 1'b1, 5'd7, addr);
        advance();
        ifc.ex_to_mem_bus   = '0;
        ifc.data_sram_rdata = rd;
        @(negedge clk);
        checks++;
        if (ifc.mem_to_wb_bus[31:0] !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, ifc.mem_to_wb_bus[31:0], exp);
        end
        checks++;
        if (ifc.mem_to_wb_bus !== model_wb()) begin
            failures++;
            $display("FAIL %s_bus got=%h exp=%h", name, ifc.mem_to_wb_bus, model_wb());
        end
        advance();
    endtask

    task automatic test_loads();
        advance();
        run_load("lb_addr3",  4'b0001, 32'h1000_0003, 32'h8012_3456, 32'hFFFF_FF80);
        run_load("lhu_addr2", 4'b0100, 32'h1000_0002, 32'h9ABC_1234, 32'h0000_9ABC);
        run_load("lh_addr2",  4'b0011, 32'h1000_0002, 32'h9ABC_1234, 32'hFFFF_9ABC);
        run_load("lbu_addr1", 4'b0010, 32'h1000_0001, 32'h1234_F678, 32'h0000_00F6);
        run_load("lh_addr1",  4'b0011, 32'h1000_0001, 32'h1234_8001, 32'hFFFF_8001);
        run_load("lw_odd",    4'b1010, 32'h1000_0000, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
    endtask

    task automatic test_hold();
        ifc.stall         = 6'd0;
        ifc.ex_to_mem_bus = mk(4'b1111, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0040_0200,
                               1'b1, 4'b0000, 1'b1, 1'b1, 5'd9, 32'h2000_0000);
        advance();
        ifc.ex_to_mem_bus   = '0;
        ifc.data_sram_rdata = 32'h1122_3344;
        @(negedge clk);
        checks++;
        if (ifc.mem_to_wb_bus[31:0] !== 32'h1122_3344) begin
            failures++;
            $display("FAIL hold_first got=%h exp=11223344", ifc.mem_to_wb_bus[31:0]);
        end
        ifc.stall = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            advance();
            ifc.data_sram_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            checks++;
            if (ifc.mem_to_wb_bus[31:0] !== 32'h1122_3344 || ifc.mem_to_wb_bus[37] !== 1'b1) begin
                failures++;
                $display("FAIL hold_cycle%0d got=%h exp=11223344", i, ifc.mem_to_wb_bus[31:0]);
            end
        end
        ifc.stall = 6'd0;
        advance();
        @(negedge clk);
        checks++;
        if (ifc.mem_to_wb_bus !== 136'd0) begin
            failures++;
            $display("FAIL hold_release got=%h exp=0", ifc.mem_to_wb_bus);
        end
    endtask

    task automatic test_bubble();
        ifc.stall         = 6'd0;
        ifc.ex_to_mem_bus = mk(4'b0000, 1'b1, 1'b1, 32'h5, 32'h6, 32'h0040_0300,
                               1'b0, 4'b0000, 1'b0, 1'b1, 5'd3, 32'h1234_5678);
        advance();
        ifc.stall = 6'b001000;
        advance();
        @(negedge clk);
        checks++;
        if (ifc.mem_to_wb_bus !== 136'd0) begin
            failures++;
            $display("FAIL bubble_bus got=%h exp=0", ifc.mem_to_wb_bus);
        end
        checks++;
        if ({ifc.mem_to_wb_bus[135:134], ifc.mem_to_wb_bus[37]} !== 3'b000) begin
            failures++;
            $display("FAIL bubble_we got=%b exp=000",
                     {ifc.mem_to_wb_bus[135:134], ifc.mem_to_wb_bus[37]});
        end
        ifc.stall         = 6'd0;
        ifc.ex_to_mem_bus = '0;
        advance();
    endtask

    task automatic test_mult();
        ifc.stall         = 6'd0;
        ifc.ex_to_mem_bus = mk(4'b0000, 1'b1, 1'b1, 32'h1, 32'h2, 32'h0040_0400,
                               1'b0, 4'b0000, 1'b0, 1'b0, 5'd0, 32'h0);
        advance();
        ifc.ex_to_mem_bus = '0;
        @(negedge clk);
        checks++;
        if (ifc.mem_to_wb_bus[135:70] !== {2'b11, 32'h1, 32'h2}) begin
            failures++;
            $display("FAIL mult_wb got=%h exp=%h", ifc.mem_to_wb_bus[135:70], {2'b11, 32'h1, 32'h2});
        end
        checks++;
        if (ifc.mem_to_id_bus[103:38] !== {2'b11, 32'h1, 32'h2}) begin
            failures++;
            $display("FAIL mult_id got=%h exp=%h", ifc.mem_to_id_bus[103:38], {2'b11, 32'h1, 32'h2});
        end
        advance();
    endtask

    task automatic test_reset_mid_hold();
        ifc.stall         = 6'd0;
        ifc.ex_to_mem_bus = mk(4'b1111, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0040_0500,
                               1'b1, 4'b0000, 1'b1, 1'b1, 5'd11, 32'h3000_0004);
        advance();
        ifc.ex_to_mem_bus   = '0;
        ifc.data_sram_rdata = 32'h5555_AAAA;
        ifc.stall           = 6'b011000;
        advance();
        ifc.data_sram_rdata = 32'h0BAD_0BAD;
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (ifc.mem_to_wb_bus !== 136'd0 || ifc.mem_to_id_bus !== 104'd0) begin
            failures++;
            $display("FAIL rst_midhold got=%h exp=0", ifc.mem_to_wb_bus);
        end
        #1 resetn = 1'b1;
        ifc.stall         = 6'd0;
        ifc.ex_to_mem_bus = mk(4'b1111, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0040_0600,
                               1'b1, 4'b0000, 1'b1, 1'b1, 5'd12, 32'h3000_0008);
        advance();
        ifc.ex_to_mem_bus   = '0;
        ifc.data_sram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if (ifc.mem_to_wb_bus[31:0] !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL rst_live got=%h exp=cafef00d", ifc.mem_to_wb_bus[31:0]);
        end
        advance();
    endtask

    task automatic test_random();
        logic [3:0]  codes [6];
        logic [3:0]  rd_code;
        logic        en;
        logic [3:0]  wen;
        int unsigned r;
        codes[0] = 4'b1111; codes[1] = 4'b0001; codes[2] = 4'b0010;
        codes[3] = 4'b0011; codes[4] = 4'b0100; codes[5] = 4'b0110;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            ifc.stall = (r < 5) ? 6'b000000 : (r < 8) ? 6'b011000 : 6'b001000;
            ifc.stall[2:0] = 3'($urandom);
            ifc.stall[5]   = 1'($urandom);
            rd_code = codes[$urandom_range(0, 5)];
            en      = ($urandom_range(0, 3) != 0);
            wen     = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            ifc.ex_to_mem_bus = mk(rd_code, 1'($urandom), 1'($urandom), $urandom, $urandom,
                                   $urandom, en, wen, en && (wen == 4'b0000),
                                   1'($urandom), 5'($urandom), $urandom);
            advance();
            ifc.data_sram_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (ifc.mem_to_wb_bus !== model_wb()) begin
                failures++;
                $display("FAIL rand_wb[%0d] got=%h exp=%h", n, ifc.mem_to_wb_bus, model_wb());
            end
            checks++;
            if (ifc.mem_to_id_bus !== id_of(model_wb())) begin
                failures++;
                $display("FAIL rand_id[%0d] got=%h exp=%h", n, ifc.mem_to_id_bus, id_of(model_wb()));
            end
        end
        ifc.stall = 6'd0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_loads();
        test_hold();
        test_bubble();
        test_mult();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
